// File: rtl/ccgrcg_bist_pkg.sv
// Shared widths, polynomial tap masks and FSM states for the netlist BIST controller.
package ccgrcg_bist_pkg;
  localparam int IN_W  = 21;
  localparam int OUT_W = 19;
  localparam int CNT_W = 16;

  // x^21 + x^19 + 1 feeds from bits 20 and 18; x^19 + x^6 + x^2 + x + 1 from bits 18,5,1,0.
  localparam logic [IN_W-1:0]  LFSR_TAPS = 21'h140000;
  localparam logic [OUT_W-1:0] MISR_TAPS = 19'h40023;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/ccgrcg_bist_misr.sv
// Multiple-input signature register: shifts with polynomial feedback and XORs in i_dat when enabled.
// One cycle from i_en to o_sig; no backpressure, i_clr wins over i_en.
module bist_misr
  import ccgrcg_bist_pkg::*;
#(
  parameter int           W    = OUT_W,
  parameter logic [W-1:0] TAPS = W'(MISR_TAPS)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_sig
);
  logic [W-1:0] r_sig;
  logic         w_fb;

  assign w_fb  = ^(r_sig & TAPS);
  assign o_sig = r_sig;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_sig <= '0;
    end else if (i_en) begin
      r_sig <= {r_sig[W-2:0], w_fb} ^ i_dat;
    end
  end
endmodule

// File: rtl/ccgrcg_bist.sv
// BIST driver: LFSR stimulus into a netlist, MISR compaction of its outputs, golden compare.
// One vector per cycle in RUN; capture trails x_vec by DUT_LAT+1 cycles; start ignored while busy.
module ccgrcg_bist_ctrl
  import ccgrcg_bist_pkg::*;
#(
  parameter int                IN_W    = ccgrcg_bist_pkg::IN_W,
  parameter int                OUT_W   = ccgrcg_bist_pkg::OUT_W,
  parameter int                CNT_W   = ccgrcg_bist_pkg::CNT_W,
  parameter int                DUT_LAT = 0,
  parameter logic [IN_W-1:0]   SEED    = 21'h000001
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_num_patterns,
  input  logic [OUT_W-1:0] i_golden,
  output logic [IN_W-1:0]  o_x_vec,
  input  logic [OUT_W-1:0] i_f_vec,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [OUT_W-1:0] o_signature,
  output logic [CNT_W-1:0] o_pat_count
);
  localparam logic [IN_W-1:0] SEED_EFF = (SEED == '0) ? IN_W'(1) : SEED;
  localparam logic [2:0]      LAT3     = 3'(DUT_LAT);

  state_t           r_state;
  logic [CNT_W-1:0] r_np;
  logic [OUT_W-1:0] r_golden;
  logic [IN_W-1:0]  r_lfsr;
  logic [IN_W-1:0]  r_x;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [DUT_LAT:0] r_vld_pipe;
  logic [2:0]       r_drain;

  logic [OUT_W-1:0] w_sig;
  logic [IN_W-1:0]  w_lfsr_nxt;
  logic             w_cap;

  assign w_lfsr_nxt = {r_lfsr[IN_W-2:0], ^(r_lfsr & IN_W'(LFSR_TAPS))};
  assign w_cap      = r_vld_pipe[DUT_LAT];

  bist_misr #(.W(OUT_W), .TAPS(OUT_W'(MISR_TAPS))) u_misr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (r_state == LOAD),
    .i_en  (w_cap),
    .i_dat (i_f_vec),
    .o_sig (w_sig)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_np       <= '0;
      r_golden   <= '0;
      r_lfsr     <= '0;
      r_x        <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_vld_pipe <= '0;
      r_drain    <= '0;
    end else begin
      // Valid tracks each applied vector through the netlist latency.
      r_vld_pipe[0] <= (r_state == RUN);
      for (int i = 1; i <= DUT_LAT; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
      end

      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_np     <= i_num_patterns;
            r_golden <= i_golden;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_state  <= LOAD;
          end
        end
        LOAD: begin
          r_lfsr <= SEED_EFF;
          r_cnt  <= '0;
          r_x    <= '0;
          if (r_np == '0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_state <= RUN;
          end
        end
        RUN: begin
          r_x    <= r_lfsr;
          r_lfsr <= w_lfsr_nxt;
          r_cnt  <= r_cnt + 1'b1;
          if (CNT_W'(r_cnt + 1'b1) == r_np) begin
            r_drain <= '0;
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (r_drain == LAT3) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_x_vec     = r_x;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_done && (w_sig == r_golden);
  assign o_signature = w_sig;
  assign o_pat_count = r_cnt;
endmodule

// File: tb/tb_ccgrcg_bist_ctrl.sv
// Scoreboarded bench: two controllers (netlist latency 0 and 3) against a vector-list reference model.
module tb_ccgrcg_bist_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic [15:0] np;
  logic [18:0] golden, am, xm;

  logic [20:0] x0, x1;
  logic [18:0] f0, f1, sig0, sig1;
  logic        busy0, busy1, done0, done1, pass0, pass1;
  logic [15:0] cnt0, cnt1;
  logic [18:0] d1 [3];

  always #5 clk = ~clk;

  // Model netlists: f = (x & am) ^ xm, combinational for inst 0, three-cycle delayed for inst 1.
  assign f0 = (x0[18:0] & am) ^ xm;
  always @(posedge clk) begin
    d1[0] <= (x1[18:0] & am) ^ xm;
    d1[1] <= d1[0];
    d1[2] <= d1[1];
  end
  assign f1 = d1[2];

  ccgrcg_bist_ctrl #(.DUT_LAT(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .i_num_patterns(np), .i_golden(golden),
    .o_x_vec(x0), .i_f_vec(f0), .o_busy(busy0), .o_done(done0), .o_pass(pass0),
    .o_signature(sig0), .o_pat_count(cnt0));

  ccgrcg_bist_ctrl #(.DUT_LAT(3)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_num_patterns(np), .i_golden(golden),
    .o_x_vec(x1), .i_f_vec(f1), .o_busy(busy1), .o_done(done1), .o_pass(pass1),
    .o_signature(sig1), .o_pat_count(cnt1));

  typedef struct {
    logic [18:0] sig;
    logic        pass;
    int          cnt;
    int          bcyc;
    logic [20:0] xlast;
  } exp_t;

  exp_t        q0[$], q1[$];
  logic [20:0] xq0[$], xq1[$];
  int          tests = 0, fails = 0;
  int          bc[2], pc[2];
  logic        pd[2];

  task automatic check(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor step for one instance: checks each applied vector and the result on done rising.
  task automatic mon(int w, logic busy, logic done, logic pass, logic [18:0] sig,
                     logic [15:0] cnt, logic [20:0] x);
    exp_t        e;
    logic [20:0] xv;
    string       p;
    p = (w == 0) ? "i0" : "i1";
    if (busy) bc[w]++;
    if (int'(cnt) != pc[w] && cnt != 0) begin
      if (w == 0 ? xq0.size() == 0 : xq1.size() == 0) check({p, "_x_extra"}, 1, 0);
      else begin
        xv = (w == 0) ? xq0.pop_front() : xq1.pop_front();
        check({p, "_x_vec"}, x, xv);
      end
    end
    pc[w] = int'(cnt);
    if (done && !pd[w]) begin
      if (w == 0 ? q0.size() == 0 : q1.size() == 0) check({p, "_sb_empty"}, 1, 0);
      else begin
        e = (w == 0) ? q0.pop_front() : q1.pop_front();
        check({p, "_signature"}, sig, e.sig);
        check({p, "_pass"}, pass, e.pass);
        check({p, "_pat_count"}, cnt, e.cnt);
        check({p, "_busy_cycles"}, bc[w], e.bcyc);
        check({p, "_x_hold"}, x, e.xlast);
        check({p, "_busy_in_done"}, busy, 0);
      end
      bc[w] = 0;
    end
    pd[w] = done;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        bc[i] = 0; pc[i] = 0; pd[i] = 1'b0;
      end
    end else begin
      mon(0, busy0, done0, pass0, sig0, cnt0, x0);
      mon(1, busy1, done1, pass1, sig1, cnt1, x1);
    end
  end

  task automatic set_start(int w, logic v);
    if (w == 0) start0 = v; else start1 = v;
  endtask

  // Reference: vector list from the seed-1 maximal LFSR, signature by polynomial division.
  task automatic plan(int w, int n, logic [18:0] a, logic [18:0] xo, int gmode, logic [18:0] gfix);
    logic [20:0] l, last;
    logic [18:0] m, f;
    exp_t        e;
    l = 21'h1; m = '0; last = '0;
    am = a; xm = xo;
    for (int k = 0; k < n; k++) begin
      if (w == 0) xq0.push_back(l); else xq1.push_back(l);
      last = l;
      f = (l[18:0] & a) ^ xo;
      m = ((m << 1) | 19'($countones(m & 19'h40023) % 2)) ^ f;
      l = (l << 1) | 21'(((l >> 20) ^ (l >> 18)) & 21'h1);
    end
    golden = (gmode == 1) ? m : (gmode == 2) ? gfix : 19'($urandom);
    e.sig   = m;
    e.pass  = (m == golden);
    e.cnt   = n;
    e.bcyc  = (n == 0) ? 1 : n + ((w == 0) ? 0 : 3) + 2;
    e.xlast = last;
    if (w == 0) q0.push_back(e); else q1.push_back(e);
    np = 16'(n);
  endtask

  task automatic run(int w, int n, logic [18:0] a, logic [18:0] xo, int gmode,
                     logic [18:0] gfix, bit pester);
    int budget;
    plan(w, n, a, xo, gmode, gfix);
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    budget = n + 30;
    while (!(w == 0 ? done0 : done1) && budget > 0) begin
      if (pester) set_start(w, (w == 0 ? busy0 : busy1) ? 1'($urandom) : 1'b0);
      @(posedge clk); #1;
      budget--;
    end
    set_start(w, 1'b0);
    if (budget == 0) check("run_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(string p);
    check({p, "_x0"}, x0, 0);       check({p, "_busy0"}, busy0, 0);
    check({p, "_done0"}, done0, 0); check({p, "_pass0"}, pass0, 0);
    check({p, "_sig0"}, sig0, 0);   check({p, "_cnt0"}, cnt0, 0);
    check({p, "_x1"}, x1, 0);       check({p, "_done1"}, done1, 0);
    check({p, "_sig1"}, sig1, 0);   check({p, "_cnt1"}, cnt1, 0);
  endtask

  initial begin
    int budget;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; np = '0; golden = '0; am = '0; xm = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run(0, 5, 19'h0, 19'h0, 2, 19'h0, 0);
    run(0, 2, 19'h0, 19'h1, 2, 19'h2, 0);
    run(0, 2, 19'h0, 19'h1, 2, 19'h3, 0);
    run(0, 0, 19'h0, 19'h0, 2, 19'h0, 0);
    run(0, 4, 19'h7FFFF, 19'h0, 1, 19'h0, 0);
    run(1, 4, 19'h7FFFF, 19'h0, 1, 19'h0, 0);
    run(1, 0, 19'h0, 19'h0, 0, 19'h0, 0);

    // Abort mid-run, then the same run from scratch.
    plan(0, 10, 19'h5A5A5, 19'h12345, 1, 19'h0);
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    budget = 40;
    while (cnt0 != 16'd2 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) check("abort_wait_timeout", 0, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_zero("abort");
    rst = 1'b0;
    q0.delete(); xq0.delete();
    @(posedge clk); #1;
    run(0, 10, 19'h5A5A5, 19'h12345, 1, 19'h0, 0);

    run(0, 12, 19'($urandom), 19'($urandom), 1, 19'h0, 1);
    run(1, 12, 19'($urandom), 19'($urandom), 0, 19'h0, 1);

    for (int i = 0; i < 14; i++) begin
      run(int'($urandom_range(0, 1)), int'($urandom_range(0, 40)), 19'($urandom),
          19'($urandom), int'($urandom_range(0, 1)), 19'h0, bit'($urandom_range(0, 1)));
    end
    run(1, 300, 19'($urandom), 19'($urandom), 1, 19'h0, 0);

    check("sb_leftover", q0.size() + q1.size() + xq0.size() + xq1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ccgrcg_bist_ctrl.md
Name: ccgrcg_bist_ctrl

Overview:
Built-in self-test driver and response compactor for the 21-input / 19-output combinational benchmark netlists (x0..x20 → f1..f19) in the dataset.
- Drives pseudo-random input vectors into the netlist.
- Compacts the returned output vectors into a 19-bit MISR signature.
- Compares the signature against a golden value.
- Sits between the dataset-harness host (start/result) and one netlist instance, wired as x_vec[i] → xi and f_vec[j-1] ← fj.

Parameters:
IN_W, 21, netlist input width (LFSR width)
OUT_W, 19, netlist output width (MISR width)
CNT_W, 16, pattern counter width
DUT_LAT, 0, cycles from x_vec change to valid f_vec (0 = purely combinational netlist); range 0..7
SEED, 21'h000001, LFSR seed; a seed of zero is replaced by 1

Ports:
clk  in  1  single clock; all state changes on its rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a test run; sampled only in IDLE
num_patterns  in  CNT_W  number of vectors to apply; captured on accepted start
golden  in  OUT_W  expected signature; captured on accepted start
x_vec  out  IN_W  registered stimulus to netlist inputs
f_vec  in  OUT_W  netlist outputs
busy  out  1  high from accepted start until DONE is entered
done  out  1  high while in DONE
pass  out  1  signature == golden; valid only while done=1
signature  out  OUT_W  current MISR contents
pat_count  out  CNT_W  patterns applied so far

Behaviour:
- Reset values: x_vec=0, busy=0, done=0, pass=0, signature=0, pat_count=0, state=IDLE, capture pipeline cleared. rst asserted in any state aborts the run and restores all of these on the next edge.
- LFSR: shift left, bit0 ← l[20]^l[18] (x^21+x^19+1, maximal length).
- MISR update: m ← {m[17:0], m[18]^m[5]^m[1]^m[0]} ^ f_vec (x^19+x^6+x^2+x+1).
- FSM states: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE: x_vec held 0. start=1 → LOAD; captures num_patterns and golden.
- LOAD (1 cycle):
  - lfsr ← SEED (or 1 if SEED==0); misr ← 0; pat_count ← 0; busy=1.
  - If num_patterns==0 → DONE with signature 0, else → RUN.
- RUN (one vector per cycle):
  - x_vec ← lfsr; lfsr advances; pat_count increments.
  - valid bit enters a DUT_LAT-deep shift pipe.
  - When pat_count reaches num_patterns → DRAIN.
- Capture: MISR updates in the cycle the delayed valid is high, sampling f_vec. With DUT_LAT=0 it samples the same cycle x_vec holds the vector, i.e. the cycle after x_vec is loaded.
- DRAIN: x_vec holds its last value until the pipe is empty (DUT_LAT+1 cycles), then → DONE.
- DONE:
  - busy=0, done=1, pass=(misr==golden).
  - Held until start=1, which behaves as in IDLE (→ LOAD, new capture).
- start while busy is ignored.
- pat_count saturates at num_patterns; no wrap.
- An all-ones num_patterns is legal. The LFSR period (2^21−1) exceeds the counter range, so no pattern repeats within a run.
- signature is visible every cycle; only its value in DONE is meaningful.

Decomposition:
- Package ccgrcg_bist_pkg holds:
  - IN_W, OUT_W, CNT_W defaults
  - LFSR tap constant (21,19) and MISR tap constant (19,6,2,1)
  - state enum {IDLE, LOAD, RUN, DRAIN, DONE}
- Sub-module bist_misr: OUT_W-wide MISR with load-zero and enable, reused by future netlist harnesses.
- LFSR and FSM stay inline.

Test Plan:
- DUT_LAT=0, f_vec tied 0, start with num_patterns=5 → x_vec sequence 21'h000001, 000002, 000004, 000008, 000010; done after 7 cycles in total; signature=0; pass=1 with golden=0.
- DUT_LAT=0, f_vec=19'h00001 constant, num_patterns=2, golden=19'h00002 → signature 19'h00001 then 19'h00002; pass=1. Same run with golden=19'h00003 → pass=0.
- num_patterns=0 → LOAD→DONE in 2 cycles; x_vec stays 0; signature=0; busy never seen high in RUN.
- DUT_LAT=3, f_vec driven as x_vec[18:0] delayed 3 cycles, num_patterns=4 → signature equals the DUT_LAT=0 run with f_vec=x_vec[18:0]; DRAIN lasts 4 cycles.
- rst pulsed mid-RUN (pat_count=2 of 10) → next cycle state IDLE, all outputs 0; a new start reproduces the full 10-pattern signature from scratch.
- start pulsed repeatedly during RUN → ignored; pat_count and signature unaffected; start in DONE begins a fresh run.
